// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: valid/ready issue stage with RAW scoreboard, NOP bubbles and perf counters.
// Define ISSUE_FWD_EN for a forwarding pipeline where only load-use hazards in slot 0 stall.
module pipe_issue_ctrl #(
    parameter int WB_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_instr,
    output logic             in_ready,
    input  logic             pipe_hold,
    input  logic             flush,
    output logic             issue_valid,
    output logic [7:0]       issue_instr,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] issued_count
);
    localparam logic [7:0] NOP = 8'hC0;

    logic [WB_LAT-1:0]      sb_v_q, sb_v_d;
    logic [WB_LAT-1:0][1:0] sb_rd_q, sb_rd_d;
    logic                   iv_q, iv_d;
    logic [7:0]             ii_q, ii_d;
    logic [CNT_W-1:0]       stall_q, stall_d, issued_q, issued_d;
    logic                   hit, accept;
    logic [1:0]             op, rd, rs1, rs2;

    assign op  = in_instr[7:6];
    assign rd  = in_instr[5:4];
    assign rs1 = in_instr[3:2];
    assign rs2 = in_instr[1:0];

`ifdef ISSUE_FWD_EN
    logic ld_q, ld_d;
    // Only the newest entry's load flag matters once ALU results are forwarded
    assign ld_d = pipe_hold ? ld_q : (accept && op == 2'b10);
    always_ff @(posedge clk) ld_q <= reset ? 1'b0 : ld_d;
    assign hit = sb_v_q[0] && ld_q && (sb_rd_q[0] == rs1 || sb_rd_q[0] == rs2);
`else
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < WB_LAT; k++)
            hit = hit | (sb_v_q[k] && (sb_rd_q[k] == rs1 || sb_rd_q[k] == rs2));
    end
`endif

    // Only ADD/SUB read registers; LOAD's low nibble is an immediate
    assign hazard   = in_valid && !op[1] && hit;
    assign in_ready = !hazard && !pipe_hold && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        iv_d    = iv_q;
        ii_d    = ii_q;
        sb_v_d  = sb_v_q;
        sb_rd_d = sb_rd_q;
        if (!pipe_hold) begin
            iv_d       = accept;
            ii_d       = accept ? in_instr : NOP;
            sb_v_d[0]  = accept && op != 2'b11;
            sb_rd_d[0] = rd;
            for (int k = 1; k < WB_LAT; k++) begin
                sb_v_d[k]  = sb_v_q[k-1];
                sb_rd_d[k] = sb_rd_q[k-1];
            end
        end
        stall_d  = (hazard && !pipe_hold && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
        issued_d = (accept && !(&issued_q)) ? issued_q + CNT_W'(1) : issued_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iv_q     <= 1'b0;
            ii_q     <= NOP;
            sb_v_q   <= '0;
            sb_rd_q  <= '0;
            stall_q  <= '0;
            issued_q <= '0;
        end else begin
            iv_q     <= iv_d;
            ii_q     <= ii_d;
            sb_v_q   <= sb_v_d;
            sb_rd_q  <= sb_rd_d;
            stall_q  <= stall_d;
            issued_q <= issued_d;
        end
    end

    assign issue_valid  = iv_q;
    assign issue_instr  = ii_q;
    assign stall_count  = stall_q;
    assign issued_count = issued_q;
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb_pipe_issue_ctrl: directed plan scenarios plus randomized run against a per-register timestamp model.
module tb_pipe_issue_ctrl;
    localparam int WB = 2;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic clk = 0, reset = 1, in_valid = 0, pipe_hold = 0, flush = 0;
    logic [7:0] in_instr = 8'hC0;
    logic in_ready, issue_valid, hazard;
    logic [7:0] issue_instr;
    logic [CW-1:0] stall_count, issued_count;

    pipe_issue_ctrl #(.WB_LAT(WB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .pipe_hold(pipe_hold), .flush(flush),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .hazard(hazard),
        .stall_count(stall_count), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    // Model: each register remembers the tick at which its latest writer issued
    int wr_tick[4];
    bit wr_ld[4];
    int tick;
    bit m_iv, m_hz, m_rdy, m_acc;
    logic [7:0] m_ii;
    int m_stall, m_issued;

    function automatic bit busy(input logic [1:0] r);
`ifdef ISSUE_FWD_EN
        return tick == wr_tick[r] && wr_ld[r];
`else
        return tick - wr_tick[r] < WB;
`endif
    endfunction

    task automatic model_reset();
        m_iv = 0; m_ii = 8'hC0; m_stall = 0; m_issued = 0; tick = 0;
        for (int r = 0; r < 4; r++) begin wr_tick[r] = -100; wr_ld[r] = 0; end
    endtask

    task automatic drive(input bit v, input logic [7:0] ins, input bit h, input bit f);
        in_valid = v; in_instr = ins; pipe_hold = h; flush = f;
        #1;
        m_hz  = in_valid && in_instr[7:6] < 2 && (busy(in_instr[3:2]) || busy(in_instr[1:0]));
        m_rdy = !m_hz && !pipe_hold && !flush;
        m_acc = in_valid && m_rdy;
    endtask

    task automatic clock();
        @(posedge clk);
        if (reset) model_reset();
        else if (!pipe_hold) begin
            tick++;
            if (m_acc) begin
                m_iv = 1; m_ii = in_instr;
                if (in_instr[7:6] != 2'b11) begin
                    wr_tick[in_instr[5:4]] = tick;
                    wr_ld[in_instr[5:4]] = in_instr[7:6] == 2'b10;
                end
            end else begin
                m_iv = 0; m_ii = 8'hC0;
            end
            if (m_hz && m_stall < CMAX) m_stall++;
            if (m_acc && m_issued < CMAX) m_issued++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1;
        drive(0, 8'hC0, 0, 0);
        clock(); clock();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 8'hC0, 0, 0);
        vectors++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", issue_valid); end
        vectors++; if (issue_instr !== 8'hC0) begin errors++; $display("FAIL rst_instr: got %h want c0", issue_instr); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        vectors++; if (stall_count !== 4'd0) begin errors++; $display("FAIL rst_stall: got %0d want 0", stall_count); end
        vectors++; if (issued_count !== 4'd0) begin errors++; $display("FAIL rst_issued: got %0d want 0", issued_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 8'h1B, 0, 0);
        vectors++; if (in_ready !== 1'b1 || hazard !== 1'b0) begin errors++; $display("FAIL b2b_first_ready: got rdy=%b hz=%b want 1/0", in_ready, hazard); end
        clock();
        vectors++; if (issue_instr !== 8'h1B || issue_valid !== 1'b1) begin errors++; $display("FAIL b2b_issue0: got %h/%b want 1b/1", issue_instr, issue_valid); end
        drive(1, 8'h4B, 0, 0);
        vectors++; if (in_ready !== 1'b1 || hazard !== 1'b0) begin errors++; $display("FAIL b2b_second_ready: got rdy=%b hz=%b want 1/0", in_ready, hazard); end
        clock();
        vectors++; if (issue_instr !== 8'h4B || issue_valid !== 1'b1) begin errors++; $display("FAIL b2b_issue1: got %h/%b want 4b/1", issue_instr, issue_valid); end
        vectors++; if (issued_count !== 4'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2", issued_count); end
    endtask

`ifdef ISSUE_FWD_EN
    task automatic test_fwd();
        do_reset();
        drive(1, 8'h1B, 0, 0); clock();
        drive(1, 8'h64, 0, 0);
        vectors++; if (hazard !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fwd_alu_nostall: got hz=%b rdy=%b want 0/1", hazard, in_ready); end
        clock();
        vectors++; if (issue_instr !== 8'h64) begin errors++; $display("FAIL fwd_alu_issue: got %h want 64", issue_instr); end
        drive(1, 8'h95, 0, 0); clock();
        drive(1, 8'h64, 0, 0);
        vectors++; if (hazard !== 1'b1) begin errors++; $display("FAIL fwd_loaduse_hz: got %b want 1", hazard); end
        clock();
        vectors++; if (issue_instr !== 8'hC0 || issue_valid !== 1'b0) begin errors++; $display("FAIL fwd_bubble: got %h/%b want c0/0", issue_instr, issue_valid); end
        drive(1, 8'h64, 0, 0);
        vectors++; if (hazard !== 1'b0) begin errors++; $display("FAIL fwd_loaduse_clear: got %b want 0", hazard); end
        clock();
        vectors++; if (issue_instr !== 8'h64) begin errors++; $display("FAIL fwd_loaduse_issue: got %h want 64", issue_instr); end
        vectors++; if (stall_count !== 4'd1) begin errors++; $display("FAIL fwd_stall_count: got %0d want 1", stall_count); end
    endtask
`else
    task automatic test_raw_stall();
        do_reset();
        drive(1, 8'h1B, 0, 0); clock();
        for (int i = 0; i < 2; i++) begin
            drive(1, 8'h64, 0, 0);
            vectors++; if (hazard !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL raw_hz%0d: got hz=%b rdy=%b want 1/0", i, hazard, in_ready); end
            clock();
            vectors++; if (issue_instr !== 8'hC0 || issue_valid !== 1'b0) begin errors++; $display("FAIL raw_bubble%0d: got %h/%b want c0/0", i, issue_instr, issue_valid); end
        end
        drive(1, 8'h64, 0, 0);
        vectors++; if (hazard !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL raw_clear: got hz=%b rdy=%b want 0/1", hazard, in_ready); end
        clock();
        vectors++; if (issue_instr !== 8'h64 || issue_valid !== 1'b1) begin errors++; $display("FAIL raw_issue: got %h/%b want 64/1", issue_instr, issue_valid); end
        vectors++; if (stall_count !== 4'd2) begin errors++; $display("FAIL raw_stall_count: got %0d want 2", stall_count); end
    endtask
`endif

    task automatic test_hold();
        do_reset();
        drive(1, 8'h1B, 0, 0); clock();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h4B, 1, 0);
            vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready%0d: got %b want 0", i, in_ready); end
            clock();
            vectors++; if (issue_instr !== 8'h1B || issue_valid !== 1'b1) begin errors++; $display("FAIL hold_issue%0d: got %h/%b want 1b/1", i, issue_instr, issue_valid); end
            vectors++; if (issued_count !== 4'd1 || stall_count !== 4'd0) begin errors++; $display("FAIL hold_counts%0d: got %0d/%0d want 1/0", i, issued_count, stall_count); end
        end
        // A frozen scoreboard still sees r1 in flight after the hold
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h64, 0, 0);
            vectors++; if (hazard !== m_hz) begin errors++; $display("FAIL hold_resume_hz%0d: got %b want %b", i, hazard, m_hz); end
            clock();
            vectors++; if (issue_instr !== m_ii) begin errors++; $display("FAIL hold_resume_issue%0d: got %h want %h", i, issue_instr, m_ii); end
        end
        vectors++; if (issue_instr !== 8'h64) begin errors++; $display("FAIL hold_resume_final: got %h want 64", issue_instr); end
        vectors++; if (stall_count !== 4'(m_stall)) begin errors++; $display("FAIL hold_resume_stall: got %0d want %0d", stall_count, m_stall); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 8'h4B, 0, 1);
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        clock();
        vectors++; if (issue_valid !== 1'b0 || issue_instr !== 8'hC0) begin errors++; $display("FAIL flush_bubble: got %b/%h want 0/c0", issue_valid, issue_instr); end
        drive(1, 8'h4B, 0, 0);
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b want 1", in_ready); end
        clock();
        vectors++; if (issue_valid !== 1'b1 || issue_instr !== 8'h4B) begin errors++; $display("FAIL flush_issue: got %b/%h want 1/4b", issue_valid, issue_instr); end
        vectors++; if (issued_count !== 4'd1) begin errors++; $display("FAIL flush_count: got %0d want 1", issued_count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom % 100) == 0;
            drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 10) == 0, ($urandom % 20) == 0);
            vectors++; if (hazard !== m_hz) begin errors++; $display("FAIL rnd_hazard c%0d: got %b want %b", c, hazard, m_hz); end
            vectors++; if (in_ready !== m_rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready, m_rdy); end
            clock();
            vectors++; if (issue_valid !== m_iv) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, issue_valid, m_iv); end
            vectors++; if (issue_instr !== m_ii) begin errors++; $display("FAIL rnd_instr c%0d: got %h want %h", c, issue_instr, m_ii); end
            vectors++; if (stall_count !== 4'(m_stall)) begin errors++; $display("FAIL rnd_stall c%0d: got %0d want %0d", c, stall_count, m_stall); end
            vectors++; if (issued_count !== 4'(m_issued)) begin errors++; $display("FAIL rnd_issued c%0d: got %0d want %0d", c, issued_count, m_issued); end
        end
        reset = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_back_to_back();
`ifdef ISSUE_FWD_EN
        test_fwd();
`else
        test_raw_stall();
`endif
        test_hold();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pipe_issue_ctrl.md
Name: pipe_issue_ctrl

Overview:
Issue controller for the 4-stage ADD/SUB/LOAD pipeline (IF, ID, EX, WB).
- Accepts 8-bit instructions from a fetch source over a valid/ready handshake.
- Detects read-after-write hazards against in-flight destinations using a scoreboard shift register.
- Issues each instruction to the EX stage one cycle after it is accepted, or inserts a NOP bubble when stalling.
- Provides stall and issue counters for performance debug.

Parameters:
- WB_LAT, 2: number of cycles after issue during which an instruction's destination register is not yet readable. This is also the scoreboard depth. Legal range is 1 to 4.
- CNT_W, 16: width of the stall and issue counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- in_valid  input  1  fetch source presents an instruction.
- in_instr  input  8  instruction. [7:6] opcode (00 ADD, 01 SUB, 10 LOAD, 11 NOP), [5:4] rd, [3:2] rs1, [1:0] rs2. For LOAD, [3:0] is a 4-bit immediate.
- in_ready  output  1  controller accepts in_instr this cycle.
- pipe_hold  input  1  downstream freeze. When high, nothing advances.
- flush  input  1  discard the next issue slot.
- issue_valid  output  1  issue_instr is a real instruction.
- issue_instr  output  8  instruction driven to the EX stage.
- hazard  output  1  combinational: the offered instruction is blocked by the scoreboard.
- stall_count  output  CNT_W  cycles lost to hazards.
- issued_count  output  CNT_W  instructions issued.

Behaviour:
- Reset, synchronous and checked at the clock edge, sets:
  - issue_valid=0 and issue_instr=8'hC0 (NOP);
  - all scoreboard slots invalid;
  - both counters to 0.
- Source operands:
  - ADD and SUB read rs1 and rs2.
  - LOAD and NOP read nothing.
  - ADD, SUB and LOAD write rd; NOP writes nothing.
- Scoreboard:
  - Slot 0 holds {valid, rd, is_load} of the instruction currently on issue_instr.
  - On every cycle with pipe_hold low, slot k moves to slot k+1 and the last slot is dropped.
  - Slot 0 loads from the newly issued instruction. On a bubble, slot 0 is loaded invalid.
  - When pipe_hold is high, the scoreboard holds.
- hazard = in_valid AND the instruction reads a register AND any valid slot has rd equal to rs1 or rs2.
- in_ready = !hazard AND !pipe_hold AND !flush.
- Accept occurs when in_valid && in_ready. Latency is exactly 1 cycle: on the next edge, issue_valid<=1 and issue_instr<=in_instr.
- When there is no accept and pipe_hold is low: issue_valid<=0 and issue_instr<=8'hC0.
- When pipe_hold is high: issue_valid and issue_instr hold, and no accept occurs.
- flush has priority over accept. The next cycle is a bubble. Scoreboard entries already in flight remain, because issued instructions still retire.
- stall_count increments on each cycle with hazard=1 and pipe_hold=0.
- issued_count increments on each accept.
- Both counters saturate at all-ones and do not wrap.
- A NOP accepted with in_valid=1 is issued and counted, and does not create a scoreboard entry.
- Reset asserted mid-stall drops the held instruction state. The source must re-present after reset; in_ready is 1 in the first cycle after reset.

Optional Feature:
- Macro: ISSUE_FWD_EN.
- Defined: the pipeline forwards ALU results.
  - Only slot 0 entries with is_load=1 cause a hazard (load-use, 1-cycle stall).
  - ADD/SUB destinations never stall.
- Undefined: the full WB_LAT-window hazard check described above applies.

Test Plan:
1. Reset, then release -> issue_valid=0, issue_instr=8'hC0, in_ready=1, stall_count=0, issued_count=0.
2. Default WB_LAT=2, no macro: back-to-back 8'h1B (ADD r1=r2+r3) then 8'h4B (SUB r0=r2-r3) -> both accepted on consecutive cycles, hazard never set, issued_count=2.
3. No macro: 8'h1B then 8'h64 (SUB r2=r1-r0) -> hazard high for 2 cycles. 8'h64 appears on issue_instr 3 cycles after 8'h1B, with two 8'hC0 bubbles between. stall_count=2.
4. ISSUE_FWD_EN defined:
   - 8'h1B then 8'h64 -> no stall.
   - 8'h95 (LOAD r1,#5) then 8'h64 -> exactly 1 bubble, stall_count=1.
5. pipe_hold=1 for 3 cycles while 8'h1B is on issue_instr and in_valid=1 -> in_ready=0, issue_instr stays 8'h1B, scoreboard frozen, counters unchanged. Normal flow resumes after release.
6. flush pulsed for 1 cycle while in_valid=1 with 8'h4B -> in_ready=0 that cycle, next issue_valid=0. 8'h4B is accepted the following cycle. issued_count counts it once.
